// File: rtl/outp_beat_serializer.sv
// Captures a wide output vector and streams it LSB-first as LANE_WIDTH-bit beats
// under valid/ready, keeping a running XOR signature of the beats accepted in each frame.
module outp_beat_serializer #(
  parameter int OUT_WIDTH  = 131,
  parameter int LANE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_valid,
  output logic                  cap_ready,
  input  logic [OUT_WIDTH-1:0]  outp_in,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic [LANE_WIDTH-1:0] ser_data,
  output logic                  ser_last,
  output logic [LANE_WIDTH-1:0] sig_out,
  output logic                  sig_valid
);

  localparam int NBEATS = (OUT_WIDTH + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SH_W   = NBEATS * LANE_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state;
  logic [SH_W-1:0]       r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [LANE_WIDTH-1:0] r_sig;
  logic                  r_sig_vld;
  logic [SH_W-1:0]       w_load;
  logic [LANE_WIDTH-1:0] w_beat;
  logic                  w_last;

  // Zero-pad the captured vector up to a whole number of beats.
  always_comb begin
    w_load = '0;
    w_load[OUT_WIDTH-1:0] = outp_in;
  end

  assign w_beat = r_shift[LANE_WIDTH-1:0];
  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_sig     <= '0;
      r_sig_vld <= 1'b0;
    end else begin
      r_sig_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cap_valid) begin
            r_shift <= w_load;
            r_cnt   <= '0;
            r_sig   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (ser_ready) begin
            r_sig   <= r_sig ^ w_beat;
            r_shift <= r_shift >> LANE_WIDTH;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state   <= S_IDLE;
              r_sig_vld <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on ser_ready or cap_valid.
  assign cap_ready = (r_state == S_IDLE);
  assign ser_valid = (r_state == S_SEND);
  assign ser_data  = w_beat;
  assign ser_last  = ser_valid && w_last;
  assign sig_out   = r_sig;
  assign sig_valid = r_sig_vld;

endmodule

// File: tb/tb_outp_beat_serializer.sv
// Bench for outp_beat_serializer: a 20-bit and a default 131-bit instance, checked every
// cycle against a beat-list model, plus directed frames with hand-computed beats.
module tb_outp_beat_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cv   [2];
  logic [130:0] vin  [2];
  logic         sr   [2];
  logic         crdy [2];
  logic         sv   [2];
  logic [7:0]   sd   [2];
  logic         sl   [2];
  logic [7:0]   so   [2];
  logic         sg   [2];

  outp_beat_serializer #(.OUT_WIDTH(20), .LANE_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .cap_valid(cv[0]), .cap_ready(crdy[0]),
    .outp_in(vin[0][19:0]), .ser_valid(sv[0]), .ser_ready(sr[0]),
    .ser_data(sd[0]), .ser_last(sl[0]), .sig_out(so[0]), .sig_valid(sg[0])
  );

  outp_beat_serializer dut1 (
    .clk(clk), .reset(reset), .cap_valid(cv[1]), .cap_ready(crdy[1]),
    .outp_in(vin[1]), .ser_valid(sv[1]), .ser_ready(sr[1]),
    .ser_data(sd[1]), .ser_last(sl[1]), .sig_out(so[1]), .sig_valid(sg[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is the list of beats cut from the masked vector; beats leave in order.
  logic [7:0] mb [2][32];
  int         mlen [2];
  int         mpos [2];
  logic [7:0] msig [2];
  logic       msv  [2];

  function automatic int width_of(input int k);
    return (k == 0) ? 20 : 131;
  endfunction

  function automatic int nbeats_of(input int k);
    return (width_of(k) + 7) / 8;
  endfunction

  task automatic model_capture(input int k);
    logic [130:0] v;
    v = vin[k];
    for (int i = 0; i < 131; i++) if (i >= width_of(k)) v[i] = 1'b0;
    for (int j = 0; j < nbeats_of(k); j++) mb[k][j] = 8'(v >> (8 * j));
    mlen[k] = nbeats_of(k);
    mpos[k] = 0;
    msig[k] = 8'h00;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mlen[k] = 0; mpos[k] = 0; msig[k] = 8'h00; msv[k] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          mlen[k] = 0; mpos[k] = 0; msig[k] = 8'h00; msv[k] = 1'b0;
        end else begin
          msv[k] = 1'b0;
          if (mpos[k] < mlen[k]) begin
            if (sr[k]) begin
              msig[k] = msig[k] ^ mb[k][mpos[k]];
              mpos[k]++;
              if (mpos[k] == mlen[k]) msv[k] = 1'b1;
            end
          end else if (cv[k]) begin
            model_capture(k);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic busy;
        busy = (mpos[k] < mlen[k]);
        check($sformatf("cap_ready%0d", k), 32'(crdy[k]), 32'(!busy));
        check($sformatf("ser_valid%0d", k), 32'(sv[k]), 32'(busy));
        check($sformatf("ser_last%0d", k), 32'(sl[k]), 32'(busy && (mpos[k] == mlen[k] - 1)));
        check($sformatf("sig_valid%0d", k), 32'(sg[k]), 32'(msv[k]));
        check($sformatf("sig_out%0d", k), 32'(so[k]), 32'(msig[k]));
        if (busy) check($sformatf("ser_data%0d", k), 32'(sd[k]), 32'(mb[k][mpos[k]]));
      end
    end
  end

  // Log of accepted beats {last,data} with cycle stamps, and of signatures at sig_valid.
  logic [8:0] lg0[$];
  logic [8:0] lg1[$];
  int         cy0[$];
  logic [7:0] sig0[$];
  logic [7:0] sig1[$];

  initial forever begin
    @(negedge clk);
    if (sv[0] === 1'b1 && sr[0] === 1'b1) begin lg0.push_back({sl[0], sd[0]}); cy0.push_back(cyc); end
    if (sv[1] === 1'b1 && sr[1] === 1'b1) lg1.push_back({sl[1], sd[1]});
    if (sg[0] === 1'b1) sig0.push_back(so[0]);
    if (sg[1] === 1'b1) sig1.push_back(so[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    lg0.delete(); lg1.delete(); cy0.delete(); sig0.delete(); sig1.delete();
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(crdy[k] === 1'b1 && sv[k] === 1'b0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_idle%0d actual=timeout expected=idle", k);
    end
    tick();
    tick();
  endtask

  task automatic capture(input int k, input logic [130:0] v);
    vin[k] = v;
    cv[k] = 1'b1;
    tick();
    cv[k] = 1'b0;
  endtask

  task automatic check_log0(input string nm, input int n, input logic [8:0] e[6]);
    check({nm, "_count"}, 32'(lg0.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < lg0.size()) check($sformatf("%s_beat%0d", nm, i), 32'(lg0[i]), 32'(e[i]));
  endtask

  task automatic check_sig0(input string nm, input int n, input logic [7:0] e0, input logic [7:0] e1);
    check({nm, "_sigcount"}, 32'(sig0.size()), 32'(n));
    if (sig0.size() > 0) check({nm, "_sig0"}, 32'(sig0[0]), 32'(e0));
    if (n > 1 && sig0.size() > 1) check({nm, "_sig1"}, 32'(sig0[1]), 32'(e1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin cv[k] = 1'b0; sr[k] = 1'b0; vin[k] = '0; end
    reset = 1'b1;
    chk_en = 1;
    repeat (3) tick();
    check("rst_cap_ready", 32'(crdy[0]), 32'd1);
    check("rst_ser_valid", 32'(sv[0]), 32'd0);
    check("rst_sig_out", 32'(so[1]), 32'd0);
    reset = 1'b0;
    tick();

    // Plain frame, ser_ready held high
    sr[0] = 1'b1;
    clear_logs();
    capture(0, 131'hABCDE);
    check("model_pin_beat2", 32'(mb[0][2]), 32'h0A);
    wait_idle(0);
    check_log0("frame", 3, '{9'h0DE, 9'h0BC, 9'h10A, 9'h0, 9'h0, 9'h0});
    if (cy0.size() == 3) begin
      check("frame_gap01", 32'(cy0[1] - cy0[0]), 32'd1);
      check("frame_gap12", 32'(cy0[2] - cy0[1]), 32'd1);
    end
    check_sig0("frame", 1, 8'h68, 8'h00);
    check("model_pin_sig", 32'(msig[0]), 32'h68);

    // Backpressure on the second beat
    clear_logs();
    capture(0, 131'hABCDE);
    tick();
    sr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", 32'(sd[0]), 32'hBC);
      check("bp_hold_last", 32'(sl[0]), 32'd0);
    end
    sr[0] = 1'b1;
    wait_idle(0);
    check_log0("bp", 3, '{9'h0DE, 9'h0BC, 9'h10A, 9'h0, 9'h0, 9'h0});
    if (cy0.size() == 3) check("bp_stall", 32'(cy0[1] - cy0[0]), 32'd4);
    check_sig0("bp", 1, 8'h68, 8'h00);

    // New capture offered mid-frame is ignored
    clear_logs();
    capture(0, 131'hABCDE);
    vin[0] = 131'h12345;
    cv[0] = 1'b1;
    tick();
    check("ign_cap_ready", 32'(crdy[0]), 32'd0);
    cv[0] = 1'b0;
    wait_idle(0);
    check_log0("ign", 3, '{9'h0DE, 9'h0BC, 9'h10A, 9'h0, 9'h0, 9'h0});
    check("ign_no_new_frame", 32'(sv[0]), 32'd0);

    // Default width, all ones: sixteen 8'hFF beats cancel, leaving 8'h07
    sr[1] = 1'b1;
    clear_logs();
    capture(1, '1);
    wait_idle(1);
    check("wide_count", 32'(lg1.size()), 32'd17);
    for (int i = 0; i < 17; i++)
      if (i < lg1.size()) check($sformatf("wide_beat%0d", i), 32'(lg1[i]), (i == 16) ? 32'h107 : 32'h0FF);
    check("wide_sigcount", 32'(sig1.size()), 32'd1);
    if (sig1.size() > 0) check("wide_sig", 32'(sig1[0]), 32'h07);

    // Reset mid-frame after beat 1 is accepted
    clear_logs();
    capture(0, 131'hABCDE);
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(sv[0]), 32'd0);
    check("mid_rst_ready", 32'(crdy[0]), 32'd1);
    tick();
    reset = 1'b0;
    check("mid_rst_sig", 32'(so[0]), 32'd0);
    clear_logs();
    capture(0, 131'h00055);
    wait_idle(0);
    check_log0("post_rst", 3, '{9'h055, 9'h000, 9'h100, 9'h0, 9'h0, 9'h0});

    // Back-to-back frames with cap_valid held
    clear_logs();
    vin[0] = 131'h00001;
    cv[0] = 1'b1;
    tick();
    vin[0] = 131'h00002;
    repeat (4) tick();
    cv[0] = 1'b0;
    wait_idle(0);
    check_log0("b2b", 6, '{9'h001, 9'h000, 9'h100, 9'h002, 9'h000, 9'h100});
    if (cy0.size() == 6) check("b2b_idle_gap", 32'(cy0[3] - cy0[2]), 32'd2);
    check_sig0("b2b", 2, 8'h01, 8'h02);

    // Randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        cv[k] = ($urandom_range(0, 3) == 0);
        sr[k] = ($urandom_range(0, 3) != 0);
        vin[k] = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (c == 300) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin cv[k] = 1'b0; sr[k] = 1'b1; end
    wait_idle(0);
    wait_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
